seq_div16x8: RTL
================

Name: seq_div16x8

Overview:
- Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor gives a 16-bit quotient and an 8-bit remainder.
- Inverse companion to the sequential 8x8 multiplier; a product can be fed back to check factors.
- Resolves one quotient bit per clock.
- state_out drives the existing seven_segment_cntrl unchanged.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width
- DIVISOR_W, 8, divisor and remainder width
- CNT_W, 4, iteration counter width (2**CNT_W >= DIVIDEND_W)

Ports:
- clk  in  1  system clock, rising edge
- reset_a  in  1  asynchronous active-high reset
- start  in  1  level request, sampled on rising clk; accepted only in IDLE, DONE or ERR
- dataa  in  16  dividend, latched on accept
- datab  in  8  divisor, latched on accept
- quotient_out  out  16  registered quotient
- remainder_out  out  8  registered remainder
- done_flag  out  1  high in DONE or ERR
- div_by_zero  out  1  high in ERR
- state_out  out  3  state code for seven-segment display

Behaviour:
- Reset:
  - reset_a high forces, asynchronously: state=IDLE, quotient_out=0, remainder_out=0, done_flag=0, div_by_zero=0, state_out=3'd0, all internal registers 0.
  - Reset asserted mid-calculation aborts the operation; outputs go to 0. No result is produced after release.
- States and encodings (state_out): IDLE=0, CALC=1, DONE=2, ERR=3. Codes 4-7 are unused; an illegal state returns to IDLE on the next edge.
- IDLE/DONE/ERR, start=1 at edge N:
  - datab!=0: latch operands, partial remainder R(9b)=0, Q shift register=dataa, count=0, go to CALC.
  - datab==0: go to ERR.
  - In both cases done_flag and div_by_zero clear on the accepting edge (ERR sets div_by_zero again).
- CALC, edges N+1..N+16, one iteration per edge:
  - T = {R[7:0], Q[15]} - {1'b0, divisor}.
  - If T is non-negative (bit 8 = 0): R=T, Q={Q[14:0],1}.
  - Else: R={R[7:0],Q[15]}, Q={Q[14:0],0}.
  - count increments by 1.
  - On the iteration where count==15: load quotient_out=final Q, remainder_out=final R[7:0], go to DONE.
- Latency: done_flag rises at edge N+16, 16 cycles after the accepting edge.
- ERR: entered at edge N+1. Sets quotient_out=16'hFFFF, remainder_out=8'hFF, div_by_zero=1, done_flag=1.
- start during CALC is ignored; operands may change freely during CALC without effect.
- start held high continuously re-triggers on the first edge in DONE/ERR. done_flag is then high for exactly one cycle per operation.
- quotient_out and remainder_out change only when entering DONE or ERR, or on reset. They hold the previous result through IDLE and CALC.
- Arithmetic is unsigned only. Result invariant: dataa == quotient_out*datab + remainder_out, with remainder_out < datab.

Test Plan:
- Basic divide: reset, then dataa=1000, datab=7, start pulse at edge N -> state_out=1 for 16 cycles; at edge N+16 quotient_out=142, remainder_out=6, done_flag=1, state_out=2.
- Extremes:
  - 16'hFFFF / 8'hFF -> quotient_out=257, remainder_out=0.
  - 5 / 200 -> quotient_out=0, remainder_out=5.
  - 16'hFFFF / 1 -> quotient_out=16'hFFFF, remainder_out=0.
- Divide by zero: dataa=100, datab=0, start -> at N+1 state_out=3, div_by_zero=1, done_flag=1, quotient_out=16'hFFFF, remainder_out=8'hFF. Then start with datab=10 -> div_by_zero clears on that edge; result is 10 r 0.
- Start during busy: dataa=1000, datab=7 accepted; start re-pulsed at cycle 5 with datab=3 and dataa changed -> ignored; result still 142 r 6 at N+16.
- Reset mid-operation: reset_a asserted asynchronously between edges N+8 and N+9 -> outputs 0 immediately, state_out=0. After release, no done_flag without a new start.
- Continuous start and random check: start held high with 1000/7 -> done_flag pulses one cycle every 17 cycles. Then 500 random non-zero operand pairs checked against quotient*divisor+remainder == dividend with remainder < divisor.

Source files
------------

// File: rtl/seq_div16x8_if.sv
// Request/result bundle for the sequential 16/8 divider.
// The master drives the operands and start; the slave returns the results and status.
interface seq_div16x8_if #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dataa;
   logic [DIVISOR_W-1:0]  datab;
   logic [DIVIDEND_W-1:0] quotient_out;
   logic [DIVISOR_W-1:0]  remainder_out;
   logic                  done_flag;
   logic                  div_by_zero;
   logic [2:0]            state_out;

   modport master (
      output start, dataa, datab,
      input  quotient_out, remainder_out, done_flag, div_by_zero, state_out
   );

   modport slave (
      input  start, dataa, datab,
      output quotient_out, remainder_out, done_flag, div_by_zero, state_out
   );
endinterface

// File: rtl/seq_div16x8.sv
// Sequential restoring divider: one quotient bit per clock, unsigned 16/8.
// state_out carries the FSM code straight to the seven-segment controller.
module seq_div16x8 #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8,
   parameter int CNT_W      = 4
) (
   input logic          clk,
   input logic          reset_a,
   seq_div16x8_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_DONE = 3'd2,
      S_ERR  = 3'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

   state_t                state_reg;
   logic [DIVISOR_W-1:0]  divisor_reg;
   logic [DIVISOR_W-1:0]  rem_reg;
   logic [DIVIDEND_W-1:0] quo_reg;
   logic [CNT_W-1:0]      count_reg;
   logic [DIVIDEND_W-1:0] quotient_reg;
   logic [DIVISOR_W-1:0]  remainder_reg;
   logic                  done_flag_reg;
   logic                  div_by_zero_reg;

   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W-1:0]  rem_next;
   logic [DIVIDEND_W-1:0] quo_next;

   // The partial remainder always stays below the divisor, so its top bit
   // is never needed and a borrow in trial[DIVISOR_W] means "restore".
   always_comb begin
      trial    = {rem_reg, quo_reg[DIVIDEND_W-1]} - {1'b0, divisor_reg};
      rem_next = '0;
      quo_next = '0;
      if (!trial[DIVISOR_W]) begin
         rem_next = trial[DIVISOR_W-1:0];
         quo_next = {quo_reg[DIVIDEND_W-2:0], 1'b1};
      end else begin
         rem_next = {rem_reg[DIVISOR_W-2:0], quo_reg[DIVIDEND_W-1]};
         quo_next = {quo_reg[DIVIDEND_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state_reg       <= S_IDLE;
         divisor_reg     <= '0;
         rem_reg         <= '0;
         quo_reg         <= '0;
         count_reg       <= '0;
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         done_flag_reg   <= 1'b0;
         div_by_zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  divisor_reg     <= bus.datab;
                  quo_reg         <= bus.dataa;
                  rem_reg         <= '0;
                  count_reg       <= '0;
                  done_flag_reg   <= 1'b0;
                  div_by_zero_reg <= 1'b0;
                  state_reg       <= S_CALC;
               end
            end

            S_CALC: begin
               // A zero divisor spends its first CALC cycle here and lands in
               // ERR one edge after acceptance.
               if (divisor_reg == '0) begin
                  quotient_reg    <= '1;
                  remainder_reg   <= '1;
                  done_flag_reg   <= 1'b1;
                  div_by_zero_reg <= 1'b1;
                  state_reg       <= S_ERR;
               end else begin
                  rem_reg   <= rem_next;
                  quo_reg   <= quo_next;
                  count_reg <= count_reg + 1'b1;
                  if (count_reg == LAST_ITER) begin
                     quotient_reg  <= quo_next;
                     remainder_reg <= rem_next;
                     done_flag_reg <= 1'b1;
                     state_reg     <= S_DONE;
                  end
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.quotient_out  = quotient_reg;
   assign bus.remainder_out = remainder_reg;
   assign bus.done_flag     = done_flag_reg;
   assign bus.div_by_zero   = div_by_zero_reg;
   assign bus.state_out     = state_reg;

endmodule
